cmp_hazard_ctrl: RTL
====================

// Module: cmp_hazard_ctrl
// PURPOSE
//   Hazard/forwarding controller for the D-stage branch comparator of the 5-stage MIPS pipeline.
//   Tracks in-flight register writes in a 3-slot E/M/W shadow pipeline.
//   For each comparator operand (rs->A, rt->B) it selects the forwarding source, or stalls D
//   until the value becomes forwardable. It also counts stall cycles for performance checks.
// PARAMETERS
//   CNT_W   32   width of stall-cycle counter (saturating)
// PORTS
//   clk          in   1      rising-edge clock
//   reset        in   1      asynchronous reset, active-low
//   D_valid      in   1      D holds a real instruction
//   D_use_cmp    in   1      D instruction reads the comparator (beq/bne/blez/bgtz/bltz/bgez/bgezalr)
//   D_rs         in   5      comparator operand A register
//   D_rt         in   5      comparator operand B register
//   D_use_rt     in   1      operand B is live (0 for single-operand branches)
//   D_we         in   1      D instruction writes a GPR
//   D_wa         in   5      D instruction destination register
//   D_rdy        in   2      first stage holding D's result: 1=E(link), 2=M(ALU), 3=W(load)
//   flush        in   1      kill E slot next edge (same effect as bubble)
//   stall        out  1      hold F/D, insert bubble into E
//   fwd_A_sel    out  2      CMP A source: 0=RF, 1=E, 2=M, 3=W
//   fwd_B_sel    out  2      CMP B source, same encoding
//   cmp_go       out  1      comparator result valid this cycle (D_valid & D_use_cmp & ~stall)
//   stall_cnt    out  CNT_W  total stall cycles since reset, saturates at all-ones
// BEHAVIOUR
//   State: slots E, M, W, each {v, wa[4:0], rdy[1:0]}, plus stall_cnt.
//   Reset (reset==0, async): all slot v=0; stall_cnt=0. With D inputs quiet, stall=0, fwd_*=0, cmp_go=0.
//   Slot update, every rising edge when reset==1:
//     W<=M; M<=E.
//     E<={D_valid & D_we & (D_wa!=0) & ~stall & ~flush, D_wa, D_rdy}.
//     Stall or flush loads a bubble into E (v=0). M and W always advance.
//   Operand lookup (combinational) for register r (A: D_rs; B: D_rt):
//     r==0: sel=0, no hazard.
//     Otherwise find the youngest valid slot with wa==r, priority E > M > W.
//     No match: sel=0.
//     Match in stage s (E=1, M=2, W=3):
//       s >= rdy: sel=s, no hazard.
//       s < rdy: hazard. sel is don't-care; drive the match stage s.
//     An older ready match must never hide a younger unready one.
//   stall = D_valid & D_use_cmp & (hazA | (D_use_rt & hazB)).
//   When D_use_rt==0, fwd_B_sel=0.
//   Latency: 0 cycles combinational from D inputs and slot state. No output is registered except stall_cnt.
//   stall_cnt increments on each edge where stall==1, until it reaches 2^CNT_W-1, then holds.
//   Simultaneous stall and flush: E takes a bubble; no double effect.
//   Reset asserted mid-stall: slots clear immediately, so stall drops in the same cycle.
//   Repeat-stall: a load immediately before a branch on its rd stalls 2 cycles.
//     Cycle 1: E match, rdy=3. Cycle 2: M match. Cycle 3: W match, sel=3, go.
//   ALU immediately before: stalls 1 cycle, then sel=2.
//   Link (rdy=1): never stalls, sel=1.
// TESTING
//   1. addu $5 in E (rdy=2), then beq $5,$6 in D -> stall=1 for 1 cycle; next cycle fwd_A_sel=2, fwd_B_sel=0, cmp_go=1; stall_cnt=1.
//   2. lw $7 issued, then bgez $7 next -> stall=1 for 2 cycles; then fwd_A_sel=3, cmp_go=1; stall_cnt=2.
//   3. addu $4 in M and lw $4 in E; branch on $4 -> youngest match wins: stall=1 (E lw), never fwd_A_sel=2 from older M.
//   4. Writes to $0 issued (D_wa=0); beq $0,$0 next -> stall=0, fwd_A_sel=fwd_B_sel=0.
//   5. lw $9 in E, flush=1 on same edge as branch stalls; also reset pulsed low mid-stall -> E cleared, stall=0 immediately on reset, stall_cnt=0.
//   6. Force 2^CNT_W+3 stall cycles with CNT_W=4 -> stall_cnt holds at 15.

Source files
------------

// File: rtl/cmp_hazard_ctrl_if.sv
// Bundle of signals between decode and the D-stage comparator hazard controller.
interface cmp_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic             D_valid;
  logic             D_use_cmp;
  logic [4:0]       D_rs;
  logic [4:0]       D_rt;
  logic             D_use_rt;
  logic             D_we;
  logic [4:0]       D_wa;
  logic [1:0]       D_rdy;
  logic             flush;
  logic             stall;
  logic [1:0]       fwd_A_sel;
  logic [1:0]       fwd_B_sel;
  logic             cmp_go;
  logic [CNT_W-1:0] stall_cnt;

  // Decode side: drives the D-stage instruction and reads back the control decisions.
  modport master (
    output D_valid, D_use_cmp, D_rs, D_rt, D_use_rt, D_we, D_wa, D_rdy, flush,
    input  stall, fwd_A_sel, fwd_B_sel, cmp_go, stall_cnt
  );

  // Controller side.
  modport slave (
    input  D_valid, D_use_cmp, D_rs, D_rt, D_use_rt, D_we, D_wa, D_rdy, flush,
    output stall, fwd_A_sel, fwd_B_sel, cmp_go, stall_cnt
  );
endinterface

// File: rtl/cmp_hazard_ctrl.sv
// Hazard/forwarding controller for the D-stage branch comparator.
// A 3-slot E/M/W shadow pipeline tracks in-flight GPR writes; each comparator operand picks
// its forwarding source or stalls D until the producing instruction reaches its ready stage.
module cmp_hazard_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input logic               clk,
  input logic               reset,
  cmp_hazard_ctrl_if.slave  bus
);

  typedef struct packed {
    logic       v;
    logic [4:0] wa;
    logic [1:0] rdy;
  } slot_t;

  slot_t            e_q, m_q, w_q;
  slot_t            e_d;
  logic [CNT_W-1:0] cnt_q;
  logic             haz_a, haz_b;
  logic [1:0]       sel_a, sel_b;
  logic             stall;

  // Returns {hazard, sel}. Youngest matching slot wins so an older ready copy can never
  // mask a younger unready producer.
  function automatic logic [2:0] lookup(input logic [4:0] r, input slot_t e, input slot_t m,
                                        input slot_t w);
    logic [2:0] res;
    res = 3'b000;
    if (r != 5'd0) begin
      if (e.v && (e.wa == r)) begin
        res = {(2'd1 < e.rdy), 2'd1};
      end else if (m.v && (m.wa == r)) begin
        res = {(2'd2 < m.rdy), 2'd2};
      end else if (w.v && (w.wa == r)) begin
        res = {(2'd3 < w.rdy), 2'd3};
      end
    end
    return res;
  endfunction

  // Operand lookup, stall decision and the next E slot.
  always_comb begin
    {haz_a, sel_a} = lookup(bus.D_rs, e_q, m_q, w_q);
    {haz_b, sel_b} = lookup(bus.D_rt, e_q, m_q, w_q);
    stall          = bus.D_valid & bus.D_use_cmp & (haz_a | (bus.D_use_rt & haz_b));
    e_d.v          = bus.D_valid & bus.D_we & (bus.D_wa != 5'd0) & ~stall & ~bus.flush;
    e_d.wa         = bus.D_wa;
    e_d.rdy        = bus.D_rdy;
  end

  assign bus.stall     = stall;
  assign bus.fwd_A_sel = sel_a;
  assign bus.fwd_B_sel = bus.D_use_rt ? sel_b : 2'd0;
  assign bus.cmp_go    = bus.D_valid & bus.D_use_cmp & ~stall;
  assign bus.stall_cnt = cnt_q;

  // Shadow pipeline advance (M and W always move; E takes a bubble on stall/flush) and
  // saturating stall counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_q   <= '0;
      m_q   <= '0;
      w_q   <= '0;
      cnt_q <= '0;
    end else begin
      e_q <= e_d;
      m_q <= e_q;
      w_q <= m_q;
      if (stall && (cnt_q != '1)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule
